// File: rtl/branch_squash_ctrl.sv
// Oldest-mispredict tracker and squash sequencer between BRU writeback and ROB/FTQ.
// Ports: clk, rst_n, i_wb_vld/i_wb_info, i_head_retire/i_head_rob_idx, i_flush -> o_pending*, o_squash_*.

package branch_squash_pkg;
    localparam int ROB_SIZE  = 64;
    localparam int ROB_IDX_W = $clog2(ROB_SIZE);
    localparam int FTQ_IDX_W = 4;
    localparam int BROB_IDX_W = 4;
    localparam int XLEN = 32;

    typedef struct packed {
        logic                 flag;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef logic [FTQ_IDX_W-1:0]  ftqIdx_t;
    typedef logic [BROB_IDX_W-1:0] brobIdx_t;

    typedef struct packed {
        robIdx_t         rob_idx;
        ftqIdx_t         ftq_idx;
        brobIdx_t        brob_idx;
        logic            has_mispred;
        logic            branch_taken;
        logic [XLEN-1:0] branch_npc;
    } branchwbInfo_t;

    typedef struct packed {
        logic            dueToBranch;
        logic            branch_taken;
        logic [XLEN-1:0] arch_pc;
    } squashInfo_t;
endpackage

module branch_squash_ctrl
    import branch_squash_pkg::*;
#(
    parameter int NUM_BRU  = 2,
    parameter int ROB_SIZE = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BRU-1:0]  i_wb_vld,
    input  branchwbInfo_t       i_wb_info [NUM_BRU],
    input  logic                i_head_retire,
    input  robIdx_t             i_head_rob_idx,
    input  logic                i_flush,
    output logic                o_pending,
    output robIdx_t             o_pending_rob_idx,
    output logic                o_squash_vld,
    output squashInfo_t         o_squash_info,
    output ftqIdx_t             o_squash_ftq_idx,
    output brobIdx_t            o_squash_brob_idx
);

    localparam int IDX_W = $clog2(ROB_SIZE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PEND   = 2'd1,
        S_SQUASH = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    branchwbInfo_t r_held;
    branchwbInfo_t w_held_nxt;
    logic          w_sq_load;

    logic          w_cand_vld;
    branchwbInfo_t w_cand;
    logic          w_ret_match;

    logic          r_pending;
    robIdx_t       r_pending_rob_idx;
    logic          r_squash_vld;
    squashInfo_t   r_squash_info;
    ftqIdx_t       r_squash_ftq_idx;
    brobIdx_t      r_squash_brob_idx;

    // Same flag: plain compare. Different flag: the one that wrapped
    // (smaller idx) is younger, so larger idx is older.
    function automatic logic older(input robIdx_t a, input robIdx_t b);
        logic [IDX_W-1:0] ai;
        logic [IDX_W-1:0] bi;
        ai = a.idx;
        bi = b.idx;
        if (a.flag == b.flag) older = (ai < bi);
        else                  older = (ai > bi);
    endfunction

    // Oldest mispredict across ports; strict compare keeps lowest port on tie.
    always_comb begin
        w_cand_vld = 1'b0;
        w_cand     = '0;
        for (int i = 0; i < NUM_BRU; i++) begin
            if (i_wb_vld[i] && i_wb_info[i].has_mispred &&
                (!w_cand_vld ||
                 older(i_wb_info[i].rob_idx, w_cand.rob_idx))) begin
                w_cand_vld = 1'b1;
                w_cand     = i_wb_info[i];
            end
        end
    end

    assign w_ret_match = i_head_retire && r_held.has_mispred &&
                         (i_head_rob_idx == r_held.rob_idx);

    always_comb begin
        w_state_nxt = r_state;
        w_held_nxt  = r_held;
        w_sq_load   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_cand_vld) begin
                    w_held_nxt  = w_cand;
                    w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                // Held branch at head: all candidates are younger.
                if (w_ret_match) begin
                    w_state_nxt = S_SQUASH;
                    w_sq_load   = 1'b1;
                end else if (w_cand_vld &&
                             older(w_cand.rob_idx, r_held.rob_idx)) begin
                    w_held_nxt = w_cand;
                end
            end
            S_SQUASH: begin
                w_state_nxt = S_IDLE;
                w_held_nxt  = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_held_nxt  = '0;
            end
        endcase
        if (i_flush) begin
            w_state_nxt = S_IDLE;
            w_held_nxt  = '0;
            w_sq_load   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_held  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_held  <= w_held_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending         <= 1'b0;
            r_pending_rob_idx <= '0;
            r_squash_vld      <= 1'b0;
            r_squash_info     <= '0;
            r_squash_ftq_idx  <= '0;
            r_squash_brob_idx <= '0;
        end else begin
            r_pending         <= (w_state_nxt != S_IDLE);
            r_pending_rob_idx <= w_held_nxt.rob_idx;
            r_squash_vld      <= w_sq_load;
            if (w_sq_load) begin
                r_squash_info.dueToBranch  <= 1'b1;
                r_squash_info.branch_taken <= r_held.branch_taken;
                r_squash_info.arch_pc      <= r_held.branch_npc;
                r_squash_ftq_idx           <= r_held.ftq_idx;
                r_squash_brob_idx          <= r_held.brob_idx;
            end
        end
    end

    assign o_pending         = r_pending;
    assign o_pending_rob_idx = r_pending_rob_idx;
    assign o_squash_vld      = r_squash_vld;
    assign o_squash_info     = r_squash_info;
    assign o_squash_ftq_idx  = r_squash_ftq_idx;
    assign o_squash_brob_idx = r_squash_brob_idx;

endmodule

// File: tb/tb_branch_squash_ctrl.sv
// Directed bench for branch_squash_ctrl.
// Drives writebacks/retire/flush, checks held index and squash pulses.

module tb_branch_squash_ctrl;
    import branch_squash_pkg::*;

    logic          clk;
    logic          rst_n;
    logic [1:0]    wb_vld;
    branchwbInfo_t wb_info [2];
    logic          head_retire;
    robIdx_t       head_rob_idx;
    logic          flush;
    logic          pending;
    robIdx_t       pending_rob_idx;
    logic          squash_vld;
    squashInfo_t   squash_info;
    ftqIdx_t       squash_ftq_idx;
    brobIdx_t      squash_brob_idx;

    int n_chk;
    int n_fail;

    branch_squash_ctrl #(.NUM_BRU(2), .ROB_SIZE(64)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_wb_vld          (wb_vld),
        .i_wb_info         (wb_info),
        .i_head_retire     (head_retire),
        .i_head_rob_idx    (head_rob_idx),
        .i_flush           (flush),
        .o_pending         (pending),
        .o_pending_rob_idx (pending_rob_idx),
        .o_squash_vld      (squash_vld),
        .o_squash_info     (squash_info),
        .o_squash_ftq_idx  (squash_ftq_idx),
        .o_squash_brob_idx (squash_brob_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic branchwbInfo_t mk(input logic f,
                                         input logic [5:0] idx,
                                         input logic mis,
                                         input logic [31:0] npc,
                                         input logic tk,
                                         input logic [3:0] ftq,
                                         input logic [3:0] brob);
        branchwbInfo_t b;
        b.rob_idx.flag  = f;
        b.rob_idx.idx   = idx;
        b.ftq_idx       = ftq;
        b.brob_idx      = brob;
        b.has_mispred   = mis;
        b.branch_taken  = tk;
        b.branch_npc    = npc;
        return b;
    endfunction

    function automatic logic [63:0] ri(input logic f, input logic [5:0] idx);
        return {57'd0, f, idx};
    endfunction

    task automatic idle_in();
        wb_vld       = '0;
        wb_info[0]   = '0;
        wb_info[1]   = '0;
        head_retire  = 1'b0;
        head_rob_idx = '0;
        flush        = 1'b0;
    endtask

    task automatic wb(input int p, input branchwbInfo_t b);
        wb_vld[p]  = 1'b1;
        wb_info[p] = b;
    endtask

    task automatic retire(input logic f, input logic [5:0] idx);
        head_retire       = 1'b1;
        head_rob_idx.flag = f;
        head_rob_idx.idx  = idx;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle_in();
        #3;
        check("rst_pend", 64'(pending), 64'd0);
        check("rst_ridx", 64'(pending_rob_idx), 64'd0);
        check("rst_sq", 64'(squash_vld), 64'd0);
        check("rst_info", 64'(squash_info), 64'd0);
        check("rst_ftq", 64'(squash_ftq_idx), 64'd0);
        check("rst_brob", 64'(squash_brob_idx), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // single mispredict
        wb(0, mk(1'b0, 6'd5, 1'b1, 32'h8000_1000, 1'b1, 4'd3, 4'd2));
        step();
        check("s_pend", 64'(pending), 64'd1);
        check("s_ridx", 64'(pending_rob_idx), ri(1'b0, 6'd5));
        step();
        retire(1'b0, 6'd4);
        step();
        check("s_nomatch_sq", 64'(squash_vld), 64'd0);
        check("s_nomatch_pend", 64'(pending), 64'd1);
        retire(1'b0, 6'd5);
        step();
        check("s_sq", 64'(squash_vld), 64'd1);
        check("s_sq_pend", 64'(pending), 64'd1);
        check("s_pc", 64'(squash_info.arch_pc), 64'h8000_1000);
        check("s_due", 64'(squash_info.dueToBranch), 64'd1);
        check("s_tk", 64'(squash_info.branch_taken), 64'd1);
        check("s_ftq", 64'(squash_ftq_idx), 64'd3);
        check("s_brob", 64'(squash_brob_idx), 64'd2);
        step();
        check("s_sq_end", 64'(squash_vld), 64'd0);
        check("s_pend_end", 64'(pending), 64'd0);

        // same-cycle arbitration
        wb(0, mk(1'b0, 6'd9, 1'b1, 32'h100, 1'b0, 4'd1, 4'd1));
        wb(1, mk(1'b0, 6'd3, 1'b1, 32'h200, 1'b0, 4'd2, 4'd2));
        step();
        check("arb_ridx", 64'(pending_rob_idx), ri(1'b0, 6'd3));
        flush = 1'b1;
        step();
        check("arb_flush", 64'(pending), 64'd0);
        wb(0, mk(1'b0, 6'd3, 1'b1, 32'h300, 1'b1, 4'd5, 4'd7));
        wb(1, mk(1'b0, 6'd3, 1'b1, 32'h400, 1'b0, 4'd6, 4'd8));
        step();
        check("tie_ridx", 64'(pending_rob_idx), ri(1'b0, 6'd3));
        retire(1'b0, 6'd3);
        step();
        check("tie_sq", 64'(squash_vld), 64'd1);
        check("tie_ftq", 64'(squash_ftq_idx), 64'd5);
        check("tie_brob", 64'(squash_brob_idx), 64'd7);
        check("tie_pc", 64'(squash_info.arch_pc), 64'h300);
        check("tie_tk", 64'(squash_info.branch_taken), 64'd1);
        step();
        check("tie_idle", 64'(pending), 64'd0);

        // wrap-around
        wb(0, mk(1'b0, 6'd62, 1'b1, 32'h500, 1'b0, 4'd0, 4'd0));
        step();
        check("wr_ridx", 64'(pending_rob_idx), ri(1'b0, 6'd62));
        wb(1, mk(1'b1, 6'd1, 1'b1, 32'h504, 1'b0, 4'd0, 4'd0));
        step();
        check("wr_young", 64'(pending_rob_idx), ri(1'b0, 6'd62));
        wb(0, mk(1'b0, 6'd60, 1'b1, 32'h508, 1'b0, 4'd0, 4'd0));
        step();
        check("wr_old", 64'(pending_rob_idx), ri(1'b0, 6'd60));
        wb(1, mk(1'b0, 6'd61, 1'b1, 32'h50c, 1'b0, 4'd0, 4'd0));
        step();
        check("wr_nrep", 64'(pending_rob_idx), ri(1'b0, 6'd60));
        flush = 1'b1;
        step();
        wb(0, mk(1'b1, 6'd1, 1'b1, 32'h600, 1'b0, 4'd0, 4'd0));
        step();
        wb(1, mk(1'b0, 6'd62, 1'b1, 32'h604, 1'b0, 4'd0, 4'd0));
        step();
        check("wr_back", 64'(pending_rob_idx), ri(1'b0, 6'd62));
        flush = 1'b1;
        step();

        // flush with same-cycle candidate
        wb(0, mk(1'b0, 6'd7, 1'b1, 32'h700, 1'b0, 4'd0, 4'd0));
        step();
        check("fl_hold", 64'(pending), 64'd1);
        flush = 1'b1;
        wb(1, mk(1'b0, 6'd2, 1'b1, 32'h704, 1'b0, 4'd0, 4'd0));
        step();
        check("fl_pend", 64'(pending), 64'd0);
        check("fl_sq", 64'(squash_vld), 64'd0);
        retire(1'b0, 6'd7);
        step();
        check("fl_nosq", 64'(squash_vld), 64'd0);
        check("fl_pend2", 64'(pending), 64'd0);

        // writeback during squash cycle is dropped
        wb(0, mk(1'b0, 6'd4, 1'b1, 32'h800, 1'b0, 4'd0, 4'd0));
        step();
        retire(1'b0, 6'd4);
        wb(1, mk(1'b0, 6'd1, 1'b1, 32'h804, 1'b0, 4'd0, 4'd0));
        step();
        check("sd_sq", 64'(squash_vld), 64'd1);
        check("sd_pc", 64'(squash_info.arch_pc), 64'h800);
        wb(0, mk(1'b0, 6'd8, 1'b1, 32'h808, 1'b0, 4'd0, 4'd0));
        step();
        check("sd_sq_end", 64'(squash_vld), 64'd0);
        check("sd_pend", 64'(pending), 64'd0);
        step();
        check("sd_pend2", 64'(pending), 64'd0);

        // flush during squash cycle
        wb(0, mk(1'b0, 6'd4, 1'b1, 32'h900, 1'b0, 4'd0, 4'd0));
        step();
        retire(1'b0, 6'd4);
        step();
        check("fs_sq", 64'(squash_vld), 64'd1);
        flush = 1'b1;
        step();
        check("fs_sq_end", 64'(squash_vld), 64'd0);
        check("fs_pend", 64'(pending), 64'd0);

        // non-mispredict traffic
        for (int c = 0; c < 100; c++) begin
            for (int p = 0; p < 2; p++) begin
                wb_vld[p]  = 1'($urandom_range(0, 1));
                wb_info[p] = mk(1'($urandom_range(0, 1)),
                                6'($urandom_range(0, 63)), 1'b0,
                                $urandom, 1'($urandom_range(0, 1)),
                                4'($urandom_range(0, 15)),
                                4'($urandom_range(0, 15)));
            end
            head_retire       = 1'($urandom_range(0, 1));
            head_rob_idx.flag = 1'($urandom_range(0, 1));
            head_rob_idx.idx  = 6'($urandom_range(0, 63));
            step();
            check("nm_pend", 64'(pending), 64'd0);
            check("nm_sq", 64'(squash_vld), 64'd0);
        end

        // asynchronous reset mid-operation
        wb(0, mk(1'b0, 6'd5, 1'b1, 32'ha00, 1'b0, 4'd0, 4'd0));
        step();
        check("ar_hold", 64'(pending), 64'd1);
        retire(1'b0, 6'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_pend", 64'(pending), 64'd0);
        check("ar_ridx", 64'(pending_rob_idx), 64'd0);
        step();
        check("ar_sq", 64'(squash_vld), 64'd0);
        rst_n = 1'b1;
        step();
        check("ar_sq2", 64'(squash_vld), 64'd0);
        check("ar_pend2", 64'(pending), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_squash_ctrl.md
# branch_squash_ctrl

Collects branch-unit writebacks, tracks the oldest mispredicted branch in flight, and sequences the pipeline squash for it. Sits between the BRU writeback ports and the ROB/FTQ. The squash is issued only once the ROB retires that branch. Squash has priority over commit, and a trap flush has priority over everything.

## Interface

Parameters:
- NUM_BRU, 2: number of branch writeback ports.
- ROB_SIZE, 64: ROB entries (power of two). robIdx_t is {flag, idx[log2(ROB_SIZE)-1:0]}.

Ports:
- clk  in  1: core clock.
- rst_n  in  1: reset; asynchronous, active-low.
- i_wb_vld  in  [NUM_BRU]: writeback valid per BRU port.
- i_wb_info  in  branchwbInfo_t[NUM_BRU]: writeback payload.
- i_head_retire  in  1: the ROB is retiring its head entry this cycle.
- i_head_rob_idx  in  robIdx_t: rob_idx of the ROB head.
- i_flush  in  1: trap/exception flush from commit.
- o_pending  out  1: a mispredicted branch is being held.
- o_pending_rob_idx  out  robIdx_t: rob_idx of the held branch. The ROB must not retire past it.
- o_squash_vld  out  1: squash pulse.
- o_squash_info  out  squashInfo_t: squash payload.
- o_squash_ftq_idx  out  ftqIdx_t: ftq_idx of the squashing branch, used for FTQ rollback.
- o_squash_brob_idx  out  brobIdx_t: brob_idx of the squashing branch.

## Operation

- Candidate: port i with i_wb_vld[i] && has_mispred. Writebacks without a mispredict are ignored.
- Age compare, older(a,b):
  - if a.flag==b.flag: a.idx < b.idx;
  - otherwise: a.idx > b.idx.
- Select the oldest candidate across all ports. On a tie in rob_idx, the lowest port wins.
- The held entry stores the full branchwbInfo_t of the selected branch.
- States:
  - IDLE: no entry held. Any candidate loads the held entry and moves to PEND.
  - PEND: replace the held entry only if the candidate is strictly older; younger or equal candidates are dropped. When i_head_retire && i_head_rob_idx == held rob_idx, move to SQUASH.
  - SQUASH: o_squash_vld=1 for exactly one cycle. All wb inputs are dropped (they are younger and being squashed). Next state is IDLE.
- squashInfo fields:
  - dueToBranch=1;
  - branch_taken = held.branch_taken;
  - arch_pc = held.branch_npc.
- i_flush has highest priority in every state:
  - next state is IDLE and the held entry is invalidated;
  - any candidate in the same cycle is dropped;
  - if i_flush arrives in SQUASH, that cycle's squash pulse still completes, and the block returns to IDLE.
- Same cycle as the PEND→SQUASH transition: the held branch is at the head, so every candidate is younger and is dropped.
- An i_head_retire whose rob_idx does not match the held entry has no effect.
- Wrap-around: idx wraps from ROB_SIZE-1 to 0 with flag toggled. The compare must stay correct across the wrap.

## Timing

- Reset values:
  - state = IDLE;
  - o_pending = 0;
  - o_pending_rob_idx = 0;
  - o_squash_vld = 0;
  - o_squash_info = all zero;
  - o_squash_ftq_idx = 0;
  - o_squash_brob_idx = 0.
- All outputs are registered.
- Writeback → o_pending / o_pending_rob_idx: 1 cycle.
- Retire-match cycle T → o_squash_vld at T+1, for exactly one cycle.
- At T+2: state = IDLE, o_pending = 0, and writebacks are accepted again.
- o_pending stays 1 through the SQUASH cycle. o_squash_info, o_squash_ftq_idx and o_squash_brob_idx are valid only while o_squash_vld = 1.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). No squash is emitted after reset.

## Test plan

- Single mispredict: port0 writes back rob_idx {0,5}, mispred, branch_npc=0x8000_1000, at cycle 0. Expected: o_pending=1 at cycle 1. Head retire {0,5} at cycle 4. Expected: o_squash_vld=1 at cycle 5 only, with arch_pc=0x8000_1000 and dueToBranch=1.
- Same-cycle arbitration: port0 rob_idx {0,9} and port1 rob_idx {0,3}, both mispred. Expected: held = {0,3}. Repeat with both at {0,3}: port0's payload is held.
- Wrap: holding {0,62} with ROB_SIZE=64. A new mispred at {1,1} is dropped. A new mispred at {0,60} replaces the held entry.
- Flush: holding {0,7}, i_flush=1 with a same-cycle mispred at {0,2}. Expected: o_pending=0 next cycle, no squash, {0,2} dropped.
- Squash-cycle drop: mispred {0,8} writes back during the SQUASH cycle of {0,4}. Expected: {0,8} ignored and o_pending=0 afterwards.
- Non-mispred writebacks only (has_mispred=0) for 100 random cycles. Expected: o_pending and o_squash_vld stay 0.
